// File: rtl/uc_seq.sv
// uc_seq: sequencing control unit for the single-cycle 8-bit microcontroller.
// Combinational opcode decode with a RUN/HALT state machine, a sticky
// illegal-opcode flag and an optional saturating retired-instruction counter.
// Optional feature macro: UC_RETCNT_EN (defined builds the retired counter;
// undefined ties retired to zero).
module uc_seq #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;

    // Raw decode results, before state/reset gating.
    logic       dec_inc;
    logic       dec_inm;
    logic       dec_we3;
    logic       dec_wez;
    logic [2:0] dec_op;
    logic       dec_legal;
    logic       dec_halt;

    // A cycle that actually executes an instruction.
    logic       run_cycle;

    assign run_cycle = (state_q == StRun) && !reset;

    // Opcode decode; low bits of ALU/LI codes carry operand fields.
    always_comb begin
        dec_inc   = 1'b1;
        dec_inm   = 1'b0;
        dec_we3   = 1'b0;
        dec_wez   = 1'b0;
        dec_op    = 3'b000;
        dec_legal = 1'b1;
        dec_halt  = 1'b0;
        casez (Opcode)
            6'b1?????: begin
                dec_op  = Opcode[4:2];
                dec_we3 = 1'b1;
                dec_wez = 1'b1;
            end
            6'b0100??: begin
                dec_inm = 1'b1;
                dec_we3 = 1'b1;
            end
            6'b000000: begin
            end
            6'b000001: dec_inc = 1'b0;
            6'b000010: dec_inc = ~z;
            6'b000011: dec_inc = z;
            6'b001111: begin
                // Target field equals own address, so the PC parks here.
                dec_inc  = 1'b0;
                dec_halt = 1'b1;
            end
            default: begin
                // Illegal codes execute as NOP.
                dec_legal = 1'b0;
            end
        endcase
    end

    // State register; reset always returns to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (dec_halt) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    // Control outputs: defaults under reset, frozen PC with no writes in HALT.
    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        Op    = 3'b000;
        if (reset) begin
            s_inc = 1'b1;
        end else if (state_q == StHalt) begin
            s_inc = 1'b0;
        end else begin
            s_inc = dec_inc;
            s_inm = dec_inm;
            we3   = dec_we3;
            wez   = dec_wez;
            Op    = dec_op;
        end
    end

    // Sticky illegal flag next state; illegal codes in HALT are ignored.
    always_comb begin
        illegal_d = illegal_q;
        if (run_cycle && !dec_legal) begin
            illegal_d = 1'b1;
        end
    end

    // Sticky illegal flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;

`ifdef UC_RETCNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    // Saturating count of legal instructions executed in RUN.
    always_comb begin
        retired_d = retired_q;
        if (run_cycle && dec_legal && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Retired counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_uc_seq.sv
// Scoreboard bench for uc_seq: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares against the DUT each cycle.
module tb_uc_seq;

    typedef struct packed {
        logic [6:0] ctl;   // {s_inc, s_inm, we3, wez, Op}
        logic       chk;   // compare registered outputs this cycle
        logic       h;
        logic       ill;
        logic [3:0] ret;
    } exp_t;

    localparam logic [6:0] CtlDef  = 7'b1000000;
    localparam logic [6:0] CtlZero = 7'b0000000;
    localparam logic [6:0] CtlAlu2 = 7'b1011010;
    localparam logic [6:0] CtlAlu1 = 7'b1011001;
    localparam logic [6:0] CtlLi   = 7'b1110000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'b111111;
    logic       z = 1'b0;
    logic       s_inc, s_inm, we3, wez;
    logic [2:0] Op;
    logic       halted, illegal;
    logic [3:0] retired;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uc_seq #(.CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .Opcode  (Opcode),
        .z       (z),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we3     (we3),
        .wez     (wez),
        .Op      (Op),
        .halted  (halted),
        .illegal (illegal),
        .retired (retired)
    );

    always #5 clk = ~clk;

    function automatic exp_t ev(logic [6:0] ctl, logic chk, logic h, logic ill,
                                logic [3:0] ret);
        exp_t e;
        e.ctl = ctl;
        e.chk = chk;
        e.h   = h;
        e.ill = ill;
`ifdef UC_RETCNT_EN
        e.ret = ret;
`else
        e.ret = 4'd0;
`endif
        return e;
    endfunction

    task automatic step(input logic r, input logic [5:0] opc, input logic zz, input exp_t e);
        @(posedge clk);
        #1;
        reset  = r;
        Opcode = opc;
        z      = zz;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the oldest expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e   = exp_q.pop_front();
            got = {s_inc, s_inm, we3, wez, Op};
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL ctl t=%0t opc=%b rst=%b z=%b got=%b exp=%b",
                         $time, Opcode, reset, z, got, e.ctl);
            end
            if (e.chk) begin
                checks++;
                if ({halted, illegal, retired} !== {e.h, e.ill, e.ret}) begin
                    errors++;
                    $display("FAIL state t=%0t got h=%b ill=%b ret=%0d exp h=%b ill=%b ret=%0d",
                             $time, halted, illegal, retired, e.h, e.ill, e.ret);
                end
            end
        end
    end

    initial begin
        // Reset with an ALU opcode present.
        step(1, 6'b111111, 0, ev(CtlDef, 0, 0, 0, 0));
        step(1, 6'b111111, 0, ev(CtlDef, 1, 0, 0, 0));
        // ALU and LI decode.
        step(0, 6'b101011, 0, ev(CtlAlu2, 1, 0, 0, 0));
        step(0, 6'b010010, 0, ev(CtlLi,   1, 0, 0, 1));
        // Branches.
        step(0, 6'b000010, 0, ev(CtlDef,  1, 0, 0, 2));
        step(0, 6'b000010, 1, ev(CtlZero, 1, 0, 0, 3));
        step(0, 6'b000011, 0, ev(CtlZero, 1, 0, 0, 4));
        step(0, 6'b000011, 1, ev(CtlDef,  1, 0, 0, 5));
        step(0, 6'b000001, 0, ev(CtlZero, 1, 0, 0, 6));
        // Illegal opcode, then 5 NOPs with the flag sticky.
        step(0, 6'b011000, 0, ev(CtlDef, 1, 0, 0, 7));
        for (int k = 0; k < 5; k++) begin
            step(0, 6'b000000, 0, ev(CtlDef, 1, 0, 1, 4'(7 + k)));
        end
        step(1, 6'b000000, 0, ev(CtlDef, 1, 0, 1, 12));
        // Halt entry and freeze.
        step(0, 6'b100100, 0, ev(CtlAlu1, 1, 0, 0, 0));
        step(0, 6'b001111, 0, ev(CtlZero, 1, 0, 0, 1));
        step(0, 6'b100100, 0, ev(CtlZero, 1, 1, 0, 2));
        step(0, 6'b100100, 1, ev(CtlZero, 1, 1, 0, 2));
        step(0, 6'b011000, 0, ev(CtlZero, 1, 1, 0, 2));
        step(0, 6'b001111, 0, ev(CtlZero, 1, 1, 0, 2));
        // Reset out of HALT, then HALT decode under reset must not halt.
        step(1, 6'b001111, 0, ev(CtlDef, 1, 1, 0, 2));
        step(1, 6'b001111, 0, ev(CtlDef, 1, 0, 0, 0));
        step(0, 6'b101011, 0, ev(CtlAlu2, 1, 0, 0, 0));
        // Saturation with a 4-bit counter.
        for (int k = 1; k <= 21; k++) begin
            step(0, 6'b000000, 0, ev(CtlDef, 1, 0, 0, (k > 15) ? 4'd15 : 4'(k)));
        end
        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
